// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: parity-mode codes,
// receiver FSM states and the 2-of-3 vote used when oversample voting is built in.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests against occupancy.
  always_comb begin
    full   = (count_r == DEPTH_C);
    empty  = (count_r == '0);
    pop_s  = pop && !empty;
    push_s = push && (!full || pop_s);
  end

  assign count    = count_r;
  assign pop_data = mem_r[rd_ptr_r];

  // Storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with free-running oversample tick and receive FIFO.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around its centre.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_TICK = 651,
  parameter int OVERSAMPLE    = 16,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 0,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          I_sys_clk,
  input  logic                          I_on_board_reset_n,
  input  logic                          I_rx_serial_data,
  output logic [DATA_BITS-1:0]          o_rx_data,
  output logic                          o_rx_valid,
  input  logic                          I_rx_ready,
  output logic                          o_baud_tick,
  output logic                          o_frame_err,
  output logic                          o_parity_err,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int TW = $clog2(CLKS_PER_TICK);
  localparam int OW = $clog2(OVERSAMPLE);

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int LAG_C = 1;
`else
  localparam int LAG_C = 0;
`endif

  // The voted decision needs the tick after the centre, so every sample slides by LAG_C.
  localparam logic [OW-1:0] HALF_C = OW'(OVERSAMPLE/2 - 2 + LAG_C);
  localparam logic [OW-1:0] FULL_C = OW'(OVERSAMPLE - 1);

  logic            sync1_r;
  logic            sync2_r;
  logic [TW-1:0]   tick_cnt_r;
  rx_state_e       state_r;
  logic [OW-1:0]   os_cnt_r;
  logic [3:0]      bit_cnt_r;
  logic            stop_cnt_r;
  logic [DATA_BITS-1:0] data_r;
  logic            par_bit_r;
  logic            frame_err_r;

  logic            rx_s;
  logic            bit_s;
  logic            sample_s;
  logic            final_stop_s;
  logic            frame_err_s;
  logic            parity_bad_s;
  logic            push_s;
  logic            pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;

  // Two-flop synchroniser on the asynchronous serial line.
  always_ff @(posedge I_sys_clk) begin
    if (!I_on_board_reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= I_rx_serial_data;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;

  // Free-running tick divider; the tick flop is high while the counter sits at its last value.
  always_ff @(posedge I_sys_clk) begin
    if (!I_on_board_reset_n) begin
      tick_cnt_r  <= '0;
      o_baud_tick <= 1'b0;
    end else begin
      tick_cnt_r  <= (tick_cnt_r == TW'(CLKS_PER_TICK - 1)) ? '0 : tick_cnt_r + 1'b1;
      o_baud_tick <= (tick_cnt_r == TW'(CLKS_PER_TICK - 2));
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_r;

  // Line history at the two previous ticks.
  always_ff @(posedge I_sys_clk) begin
    if (!I_on_board_reset_n) begin
      vote_r <= 2'b11;
    end else if (o_baud_tick) begin
      vote_r <= {vote_r[0], rx_s};
    end else begin
      vote_r <= vote_r;
    end
  end

  assign bit_s = maj3(vote_r[1], vote_r[0], rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Sample strobes and frame-completion decision.
  always_comb begin
    case (state_r)
      START:               sample_s = o_baud_tick && (os_cnt_r == HALF_C);
      DATA, PARITY, STOP:  sample_s = o_baud_tick && (os_cnt_r == FULL_C);
      default:             sample_s = 1'b0;
    endcase
    final_stop_s = sample_s && (state_r == STOP) && (stop_cnt_r == 1'(STOP_BITS - 1));
    frame_err_s  = frame_err_r | ~bit_s;
    if (PARITY_MODE == PARITY_NONE) begin
      parity_bad_s = 1'b0;
    end else begin
      parity_bad_s = ((^data_r) ^ par_bit_r) != (PARITY_MODE == PARITY_ODD);
    end
    push_s = final_stop_s && !frame_err_s && !parity_bad_s;
    pop_s  = o_rx_valid && I_rx_ready;
  end

  // Receiver FSM with registered status pulses.
  always_ff @(posedge I_sys_clk) begin
    if (!I_on_board_reset_n) begin
      state_r      <= IDLE;
      os_cnt_r     <= '0;
      bit_cnt_r    <= 4'd0;
      stop_cnt_r   <= 1'b0;
      data_r       <= '0;
      par_bit_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      o_frame_err  <= final_stop_s && frame_err_s;
      o_parity_err <= final_stop_s && !frame_err_s && parity_bad_s;
      o_overflow   <= push_s && fifo_full_s && !pop_s;
      case (state_r)
        IDLE: begin
          if (o_baud_tick && !rx_s) begin
            state_r  <= START;
            os_cnt_r <= '0;
          end
        end
        START: begin
          if (sample_s) begin
            os_cnt_r  <= '0;
            bit_cnt_r <= 4'd0;
            state_r   <= bit_s ? IDLE : DATA;
          end else if (o_baud_tick) begin
            os_cnt_r <= os_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (sample_s) begin
            os_cnt_r <= '0;
            data_r   <= {bit_s, data_r[DATA_BITS-1:1]};
            if (bit_cnt_r == 4'(DATA_BITS - 1)) begin
              bit_cnt_r   <= 4'd0;
              stop_cnt_r  <= 1'b0;
              frame_err_r <= 1'b0;
              state_r     <= (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end else if (o_baud_tick) begin
            os_cnt_r <= os_cnt_r + 1'b1;
          end
        end
        PARITY: begin
          if (sample_s) begin
            os_cnt_r  <= '0;
            par_bit_r <= bit_s;
            state_r   <= STOP;
          end else if (o_baud_tick) begin
            os_cnt_r <= os_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (final_stop_s) begin
            state_r <= IDLE;
          end else if (sample_s) begin
            os_cnt_r    <= '0;
            stop_cnt_r  <= stop_cnt_r + 1'b1;
            frame_err_r <= frame_err_s;
          end else if (o_baud_tick) begin
            os_cnt_r <= os_cnt_r + 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (I_sys_clk),
    .rst_n     (I_on_board_reset_n),
    .push      (push_s),
    .push_data (data_r),
    .pop       (pop_s),
    .pop_data  (o_rx_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (o_fifo_count)
  );

  assign o_rx_valid = !fifo_empty_s;

endmodule
